gs_project_sub: RTL and testbench

Parametrised projection-subtract unit for the Gram-Schmidt / QR stage of the eigenvalue datapath. It computes aj_new = aj − (dot / rii_2) · ai for an N-element column pair in signed fixed point. It uses an internal sequential divider and a single time-shared multiplier, with no vendor IP. It sits between the dot-product/norm stage and the column write-back, and uses a valid/ready handshake on both sides.

---
 rtl/gs_project_sub_if.sv | 27 ++
 rtl/gs_project_sub.sv | 172 +++++++++++++++++
 tb/tb_gs_project_sub.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gs_project_sub_if.sv
// Handshake bundle for gs_project_sub: input transaction side and result side.
// Vectors pack element k at bits [k*W +: W].
interface gs_project_sub_if #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 16
);
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   in_rii_2;
   logic [W-1:0]   in_dot;
   logic [N*W-1:0] in_ai;
   logic [N*W-1:0] in_aj;
   logic           out_valid;
   logic           out_ready;
   logic [N*W-1:0] out_aj_new;
   logic           out_div_zero;

   modport master (
      output in_valid, in_rii_2, in_dot, in_ai, in_aj, out_ready,
      input  in_ready, out_valid, out_aj_new, out_div_zero
   );

   modport slave (
      input  in_valid, in_rii_2, in_dot, in_ai, in_aj, out_ready,
      output in_ready, out_valid, out_aj_new, out_div_zero
   );
endinterface

// File: rtl/gs_project_sub.sv
// Projection-subtract aj_new = aj - (dot / rii_2) * ai in signed fixed point.
// Restoring divider, then one shared multiplier walks the N elements.
module gs_project_sub #(
   parameter int unsigned N    = 4,
   parameter int unsigned W    = 16,
   parameter int unsigned FRAC = 10
) (
   input logic             clk,
   input logic             rst,
   gs_project_sub_if.slave bus
);

   localparam int unsigned QW   = W + FRAC;
   localparam int unsigned CntW = $clog2(QW + N);
   localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
   localparam logic [QW-1:0] QMagMax = QW'(1) << (W - 1);

   typedef enum logic [1:0] {StIdle, StDiv, StMac, StDone} state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [W-1:0]        dvs_q, dvs_d;
   logic [W-1:0]        rem_q, rem_d;
   logic [QW-1:0]       quo_q, quo_d;
   logic                neg_q, neg_d;
   logic                dz_q, dz_d;
   logic signed [W-1:0] ai_q [N];
   logic signed [W-1:0] ai_d [N];
   logic signed [W-1:0] aj_q [N];
   logic signed [W-1:0] aj_d [N];
   logic signed [W-1:0] aj_new_q [N];
   logic signed [W-1:0] aj_new_d [N];

   logic                  in_ready, accept, div_last, mac_last;
   logic [W-1:0]          dot_abs, rii_abs;
   logic [W:0]            rem_sh;
   logic                  rem_ge;
   logic signed [W-1:0]   q_sat;
   logic [IdxW-1:0]       kidx;
   logic signed [W-1:0]   ai_k, aj_k, aj_sat;
   logic signed [2*W-1:0] prod, ps;
   logic signed [2*W:0]   diff;

   assign accept   = bus.in_valid && in_ready;
   assign div_last = (cnt_q == CntW'(QW - 1));
   assign mac_last = (cnt_q == CntW'(N - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = StDiv;
         StDiv:   if (div_last) state_d = StMac;
         StMac:   if (mac_last) state_d = StDone;
         StDone:  if (bus.out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      in_ready         = (state_q == StIdle) && !rst;
      bus.in_ready     = in_ready;
      bus.out_valid    = (state_q == StDone);
      bus.out_div_zero = dz_q;
      bus.out_aj_new   = '0;
      for (int i = 0; i < N; i++) begin
         bus.out_aj_new[i*W +: W] = aj_new_q[i];
      end
   end

   // Divider works on magnitudes; the quotient register starts as the shifted dividend.
   always_comb begin
      dot_abs = bus.in_dot[W-1] ? -bus.in_dot : bus.in_dot;
      rii_abs = bus.in_rii_2[W-1] ? -bus.in_rii_2 : bus.in_rii_2;
      rem_sh  = {rem_q, quo_q[QW-1]};
      rem_ge  = (rem_sh >= {1'b0, dvs_q});
   end

   always_comb begin
      if (dz_q) begin
         q_sat = '0;
      end else if (neg_q) begin
         q_sat = (quo_q > QMagMax) ? {1'b1, {(W-1){1'b0}}} : -quo_q[W-1:0];
      end else begin
         q_sat = (quo_q >= QMagMax) ? {1'b0, {(W-1){1'b1}}} : quo_q[W-1:0];
      end
   end

   always_comb begin
      kidx = cnt_q[IdxW-1:0];
      ai_k = ai_q[kidx];
      aj_k = aj_q[kidx];
      prod = (2*W)'(ai_k) * (2*W)'(q_sat);
      ps   = prod >>> FRAC;
      diff = {{(W+1){aj_k[W-1]}}, aj_k} - {ps[2*W-1], ps};
      if (diff[2*W:W-1] == '0 || diff[2*W:W-1] == '1) begin
         aj_sat = diff[W-1:0];
      end else begin
         aj_sat = diff[2*W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
   end

   always_comb begin
      cnt_d    = cnt_q;
      dvs_d    = dvs_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      neg_d    = neg_q;
      dz_d     = dz_q;
      ai_d     = ai_q;
      aj_d     = aj_q;
      aj_new_d = aj_new_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               cnt_d = '0;
               dvs_d = rii_abs;
               rem_d = '0;
               quo_d = QW'(dot_abs) << FRAC;
               neg_d = bus.in_dot[W-1] ^ bus.in_rii_2[W-1];
               dz_d  = (bus.in_rii_2 == '0);
               for (int i = 0; i < N; i++) begin
                  ai_d[i] = bus.in_ai[i*W +: W];
                  aj_d[i] = bus.in_aj[i*W +: W];
               end
            end
         end
         StDiv: begin
            cnt_d = div_last ? '0 : cnt_q + CntW'(1);
            rem_d = rem_ge ? W'(rem_sh - {1'b0, dvs_q}) : rem_sh[W-1:0];
            quo_d = {quo_q[QW-2:0], rem_ge};
         end
         StMac: begin
            cnt_d          = cnt_q + CntW'(1);
            aj_new_d[kidx] = aj_sat;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         dvs_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         neg_q    <= 1'b0;
         dz_q     <= 1'b0;
         ai_q     <= '{default: '0};
         aj_q     <= '{default: '0};
         aj_new_q <= '{default: '0};
      end else begin
         cnt_q    <= cnt_d;
         dvs_q    <= dvs_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         neg_q    <= neg_d;
         dz_q     <= dz_d;
         ai_q     <= ai_d;
         aj_q     <= aj_d;
         aj_new_q <= aj_new_d;
      end
   end

endmodule

// File: tb/tb_gs_project_sub.sv
// Randomized bench for gs_project_sub: arithmetic reference model, per-cycle compare process,
// plus directed cases with hand-derived results.
module tb_gs_project_sub;
   localparam int unsigned N    = 4;
   localparam int unsigned W    = 16;
   localparam int unsigned FRAC = 10;
   localparam int unsigned VW   = N * W;
   localparam int unsigned LAT  = W + FRAC + N + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   gs_project_sub_if #(.N(N), .W(W)) bus ();

   gs_project_sub #(.N(N), .W(W), .FRAC(FRAC)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic longint clamp(input longint v);
      longint lo, hi;
      lo = -(longint'(1) << (W - 1));
      hi = (longint'(1) << (W - 1)) - 1;
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   // q = dot/rii_2 in Qx.FRAC; aj_new[k] = sat(aj[k] - floor(ai[k]*q / 2^FRAC))
   function automatic logic [VW-1:0] model(input logic [W-1:0] rii, input logic [W-1:0] dot,
                                           input logic [VW-1:0] ai, input logic [VW-1:0] aj,
                                           output logic dz);
      longint r, d, mag, q, p, ps, v, scale;
      logic signed [W-1:0] e;
      logic [VW-1:0] res;
      scale = longint'(1) << FRAC;
      r = longint'($signed(rii));
      d = longint'($signed(dot));
      dz = (r == 0);
      if (dz) begin
         q = 0;
      end else begin
         mag = ((d < 0) ? -d : d) * scale / ((r < 0) ? -r : r);
         q = clamp(((d < 0) != (r < 0)) ? -mag : mag);
      end
      res = '0;
      for (int k = 0; k < N; k++) begin
         e = ai[k*W +: W];
         p = longint'(e) * q;
         ps = p / scale;
         if (p < 0 && (p % scale) != 0) ps = ps - 1;
         e = aj[k*W +: W];
         v = clamp(longint'(e) - ps);
         res[k*W +: W] = v[W-1:0];
      end
      return res;
   endfunction

   function automatic logic [VW-1:0] pk(input int a0, input int a1, input int a2, input int a3);
      logic [VW-1:0] r;
      r = {a3[15:0], a2[15:0], a1[15:0], a0[15:0]};
      return r;
   endfunction

   typedef struct {
      logic [VW-1:0] aj;
      logic          dz;
      int            acc;
   } exp_t;
   exp_t exp_q[$];

   logic          prev_rst  = 1'b0;
   logic          prev_hold = 1'b0;
   logic [VW-1:0] prev_aj   = '0;
   logic          prev_dz   = 1'b0;
   bit            busy      = 1'b0;
   bit            seen      = 1'b0;
   int            nsamp     = 0;

   always @(negedge clk) begin
      exp_t e;
      logic mdz;
      nsamp++;
      if (prev_rst) begin
         chk("rst_valid", VW'(bus.out_valid), '0);
         chk("rst_aj_new", bus.out_aj_new, '0);
         chk("rst_div_zero", VW'(bus.out_div_zero), '0);
      end
      chk("in_ready", VW'(bus.in_ready), VW'((rst || busy) ? 1'b0 : 1'b1));
      if (prev_hold) begin
         chk("hold_valid", VW'(bus.out_valid), VW'(1'b1));
         chk("hold_aj_new", bus.out_aj_new, prev_aj);
         chk("hold_div_zero", VW'(bus.out_div_zero), VW'(prev_dz));
      end
      if (exp_q.size() == 0) begin
         chk("idle_valid", VW'(bus.out_valid), '0);
      end else if (bus.out_valid === 1'b1) begin
         e = exp_q[0];
         chk("aj_new", bus.out_aj_new, e.aj);
         chk("div_zero", VW'(bus.out_div_zero), VW'(e.dz));
         if (!seen) begin
            chk("latency", VW'(nsamp - e.acc), VW'(LAT));
            seen = 1'b1;
         end
      end
      if (rst) begin
         exp_q.delete();
         busy = 1'b0;
         seen = 1'b0;
      end else begin
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            busy = 1'b0;
            seen = 1'b0;
         end
         if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
            e.aj  = model(bus.in_rii_2, bus.in_dot, bus.in_ai, bus.in_aj, mdz);
            e.dz  = mdz;
            e.acc = nsamp;
            exp_q.push_back(e);
            busy = 1'b1;
         end
      end
      prev_rst  = rst;
      prev_hold = bus.out_valid && !bus.out_ready && !rst;
      prev_aj   = bus.out_aj_new;
      prev_dz   = bus.out_div_zero;
   end

   task automatic send(input logic [W-1:0] rii, input logic [W-1:0] dot,
                       input logic [VW-1:0] ai, input logic [VW-1:0] aj);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_rii_2 = rii;
      bus.in_dot   = dot;
      bus.in_ai    = ai;
      bus.in_aj    = aj;
      @(negedge clk);
      while (bus.in_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("accept_timeout", VW'(bus.in_ready), VW'(1'b1));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out();
      int n = 0;
      @(negedge clk);
      while (bus.out_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("result_timeout", VW'(bus.out_valid), VW'(1'b1));
   endtask

   task automatic directed(input string name, input logic [W-1:0] rii, input logic [W-1:0] dot,
                           input logic [VW-1:0] ai, input logic [VW-1:0] aj,
                           input logic [VW-1:0] lit, input logic lit_dz);
      logic [VW-1:0] m;
      logic          mdz;
      m = model(rii, dot, ai, aj, mdz);
      chk({name, "_model"}, m, lit);
      chk({name, "_model_dz"}, VW'(mdz), VW'(lit_dz));
      send(rii, dot, ai, aj);
      wait_out();
      chk({name, "_dut"}, bus.out_aj_new, lit);
      chk({name, "_dut_dz"}, VW'(bus.out_div_zero), VW'(lit_dz));
      @(posedge clk);
      #1;
   endtask

   task automatic gen(output logic [W-1:0] rii, output logic [W-1:0] dot,
                      output logic [VW-1:0] ai, output logic [VW-1:0] aj);
      case ($urandom_range(0, 7))
         0: rii = '0;
         1, 2, 3: begin
            rii = W'($urandom_range(1, 4096));
            if ($urandom_range(0, 1) == 1) rii = -rii;
         end
         default: rii = W'($urandom);
      endcase
      dot = W'($urandom);
      if ($urandom_range(0, 1) == 1) dot = W'($urandom_range(0, 2047)) - W'(1024);
      for (int k = 0; k < N; k++) begin
         ai[k*W +: W] = ($urandom_range(0, 1) == 1) ? W'($urandom)
                                                    : W'($urandom_range(0, 4095)) - W'(2048);
         aj[k*W +: W] = W'($urandom);
      end
   endtask

   initial begin
      logic [W-1:0]  rii, dot;
      logic [VW-1:0] ai, aj;
      int            stall;
      bus.in_valid  = 1'b0;
      bus.in_rii_2  = '0;
      bus.in_dot    = '0;
      bus.in_ai     = '0;
      bus.in_aj     = '0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("reset_valid", VW'(bus.out_valid), '0);
      chk("reset_aj_new", bus.out_aj_new, '0);
      chk("reset_div_zero", VW'(bus.out_div_zero), '0);
      chk("reset_in_ready", VW'(bus.in_ready), '0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      directed("basic", 16'd1024, 16'd512, pk(1024, 0, 0, 0), pk(512, 1024, 0, 0),
               pk(0, 1024, 0, 0), 1'b0);
      directed("neg_floor", 16'd1024, -16'sd512, pk(1024, 1024, -1, 0), pk(-512, -512, 0, 0),
               pk(0, 0, 0, 0), 1'b0);
      directed("div_zero", 16'd0, 16'd300, pk(1024, 2048, -3000, 77), pk(5, -7, 9, 11),
               pk(5, -7, 9, 11), 1'b1);
      directed("saturate", 16'd1, 16'd32767, pk(1024, 0, 0, 0), pk(-32768, 0, 0, 0),
               pk(-32768, 0, 0, 0), 1'b0);

      // Backpressure with junk input offered while the result is held.
      bus.out_ready = 1'b0;
      gen(rii, dot, ai, aj);
      send(rii, dot, ai, aj);
      wait_out();
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         bus.in_valid = (i % 2 == 0);
         bus.in_dot   = W'($urandom);
         bus.in_ai    = {$urandom, $urandom};
      end
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      gen(rii, dot, ai, aj);
      send(rii, dot, ai, aj);
      wait_out();
      @(posedge clk);
      #1;

      // Reset while the divider is running.
      gen(rii, dot, ai, aj);
      send(rii, dot, ai, aj);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (45) @(posedge clk);
      #1;
      gen(rii, dot, ai, aj);
      send(rii, dot, ai, aj);
      wait_out();
      @(posedge clk);
      #1;

      for (int t = 0; t < 30; t++) begin
         gen(rii, dot, ai, aj);
         send(rii, dot, ai, aj);
         stall = $urandom_range(0, 3);
         bus.out_ready = (stall == 0);
         wait_out();
         if (stall > 0) begin
            repeat (stall) @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
         @(posedge clk);
         #1;
      end

      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", VW'(exp_q.size()), '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
